led_pwm_dimmer: RTL and testbench

//  Multi-channel PWM LED dimmer with per-channel programmable duty and optional linear fade.

---
 rtl/led_pwm_if.sv | 17 +
 rtl/led_pwm_dimmer.sv | 107 ++++++++++
 tb/tb_led_pwm_dimmer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_if.sv
// Duty write port for led_pwm_dimmer: request (wr_en/wr_ch/wr_duty) and its one-cycle ack/err reply.
// Latency: the reply arrives one clock after wr_en. Backpressure: none, because every clock's write is answered.
interface led_pwm_if #(
  parameter int NUM_CH    = 6,
  parameter int PWM_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [PWM_WIDTH-1:0] wr_duty;
  logic                 wr_ack;
  logic                 wr_err;

  modport master (output wr_en, wr_ch, wr_duty, input wr_ack, wr_err);
  modport slave  (input wr_en, wr_ch, wr_duty, output wr_ack, wr_err);
endinterface

// File: rtl/led_pwm_dimmer.sv
// Multi-channel PWM LED dimmer; new duties are applied only at period boundaries. Optional linear fade: LED_PWM_FADE_EN.
// Latency: led_out trails cnt/ch_on by 1 clock and wr_ack/wr_err trail wr_en by 1 clock. Backpressure: none.
module led_pwm_dimmer #(
  parameter int NUM_CH    = 6,
  parameter int PWM_WIDTH = 8,
  parameter int PRESCALE  = 1
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [NUM_CH-1:0] ch_on,
  led_pwm_if.slave          wr,
  output logic              period_start,
  output logic              fade_busy,
  output logic [NUM_CH-1:0] led_out
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'((2 ** PWM_WIDTH) - 2);

  logic [PRE_W-1:0]     pre;
  logic [PWM_WIDTH-1:0] cnt;
  logic [PWM_WIDTH-1:0] target   [NUM_CH];
  logic [PWM_WIDTH-1:0] cur_duty [NUM_CH];
  logic                 tick;
  logic                 boundary;
  logic                 wr_ok;
  logic [NUM_CH-1:0]    busy_vec;
  logic [NUM_CH-1:0]    led_nxt;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);
  assign wr_ok    = wr.wr_en && (32'(wr.wr_ch) < NUM_CH);

  // The counter wraps after MAX-1, so duty MAX keeps the LED on for every tick.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pre          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) begin
        cnt <= boundary ? '0 : cnt + PWM_WIDTH'(1);
      end
      period_start <= boundary;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= '0;
      end
      wr.wr_ack <= 1'b0;
      wr.wr_err <= 1'b0;
    end else begin
      wr.wr_ack <= wr_ok;
      wr.wr_err <= wr.wr_en && !wr_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok && (wr.wr_ch == CH_W'(i))) begin
          target[i] <= wr.wr_duty;
        end
      end
    end
  end

  // A write landing on the boundary clock is seen here only at the following boundary.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_duty[i] <= '0;
      end
    end else if (boundary) begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef LED_PWM_FADE_EN
        if (cur_duty[i] < target[i]) begin
          cur_duty[i] <= cur_duty[i] + PWM_WIDTH'(1);
        end else if (cur_duty[i] > target[i]) begin
          cur_duty[i] <= cur_duty[i] - PWM_WIDTH'(1);
        end
`else
        cur_duty[i] <= target[i];
`endif
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    led_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_vec[i] = (cur_duty[i] != target[i]);
      led_nxt[i]  = ch_on[i] && (cnt < cur_duty[i]);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      led_out   <= '0;
      fade_busy <= 1'b0;
    end else begin
      led_out   <= led_nxt;
      fade_busy <= |busy_vec;
    end
  end
endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer: a PRESCALE=1 instance (MAX=15) plus a PRESCALE=3 instance.
// Expected values follow the fade or step build, depending on whether LED_PWM_FADE_EN is defined.
module tb_led_pwm_dimmer;
  localparam int NCH = 6;
  localparam int PW  = 4;
`ifdef LED_PWM_FADE_EN
  localparam int FADE = 1;
`else
  localparam int FADE = 0;
`endif

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] ch_on;
  logic [NCH-1:0] ch_on3;
  logic           period_start;
  logic           fade_busy;
  logic [NCH-1:0] led_out;
  logic           period_start3;
  logic           fade_busy3;
  logic [NCH-1:0] led_out3;
  int             checks   = 0;
  int             failures = 0;
  int             hi [NCH];

  led_pwm_if #(.NUM_CH(NCH), .PWM_WIDTH(PW)) wr_bus ();
  led_pwm_if #(.NUM_CH(NCH), .PWM_WIDTH(PW)) wr_bus3 ();

  led_pwm_dimmer #(.NUM_CH(NCH), .PWM_WIDTH(PW), .PRESCALE(1)) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .ch_on        (ch_on),
    .wr           (wr_bus),
    .period_start (period_start),
    .fade_busy    (fade_busy),
    .led_out      (led_out)
  );

  led_pwm_dimmer #(.NUM_CH(NCH), .PWM_WIDTH(PW), .PRESCALE(3)) dut3 (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .ch_on        (ch_on3),
    .wr           (wr_bus3),
    .period_start (period_start3),
    .fade_busy    (fade_busy3),
    .led_out      (led_out3)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int ch, input int duty, input int exp_ack);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_ch   = 3'(ch);
    wr_bus.wr_duty = 4'(duty);
    step(1);
    wr_bus.wr_en = 1'b0;
    check($sformatf("wr_ack ch%0d", ch), int'(wr_bus.wr_ack), exp_ack);
    check($sformatf("wr_err ch%0d", ch), int'(wr_bus.wr_err), 1 - exp_ack);
  endtask

  task automatic wait_ps();
    int n = 0;
    while (!period_start && n < 100) begin
      step(1);
      n++;
    end
    if (!period_start) check("period_start timeout", int'(period_start), 1);
  endtask

  // Returns with period_start high, so successive calls measure back-to-back periods.
  task automatic measure();
    wait_ps();
    foreach (hi[i]) hi[i] = 0;
    for (int t = 0; t < 15; t++) begin
      step(1);
      for (int c = 0; c < NCH; c++) hi[c] += int'(led_out[c]);
    end
  endtask

  task automatic settle();
    int n = 0;
    step(1);
    while (fade_busy && n < 400) begin
      step(1);
      n++;
    end
    check("settle fade_busy", int'(fade_busy), 0);
  endtask

  initial begin
    int n;
    ch_on           = '1;
    ch_on3          = '1;
    wr_bus.wr_en    = 1'b0;
    wr_bus.wr_ch    = '0;
    wr_bus.wr_duty  = '0;
    wr_bus3.wr_en   = 1'b0;
    wr_bus3.wr_ch   = '0;
    wr_bus3.wr_duty = '0;

    // Reset values, then the first period_start 15 clocks after release.
    step(3);
    check("rst led_out", int'(led_out), 0);
    check("rst fade_busy", int'(fade_busy), 0);
    check("rst period_start", int'(period_start), 0);
    check("rst wr_ack", int'(wr_bus.wr_ack), 0);
    check("rst wr_err", int'(wr_bus.wr_err), 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!period_start && n < 100);
    check("first period_start clocks", n, 15);

    // Asynchronous reset in the middle of a period and a fade.
    do_write(0, 15, 1);
    settle();
    step(5);
    check("led0 before reset", int'(led_out[0]), 1);
    do_write(1, 7, 1);
    step(1);
    check("busy before reset", int'(fade_busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst led_out", int'(led_out), 0);
    check("async rst fade_busy", int'(fade_busy), 0);
    check("async rst period_start", int'(period_start), 0);
    step(2);
    rst_n = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!period_start && n < 100);
    check("period_start after mid reset", n, 15);
    measure();
    check("ch0 cleared by reset", hi[0], 0);
    check("ch1 cleared by reset", hi[1], 0);

    // Duty 5, 0 and 15, written back-to-back.
    do_write(0, 5, 1);
    step(1);
    check("busy after write", int'(fade_busy), 1);
    do_write(4, 0, 1);
    do_write(5, 15, 1);
    settle();
    measure();
    check("ch0 duty5 high", hi[0], 5);
    check("ch4 duty0 high", hi[4], 0);
    check("ch5 duty15 high", hi[5], 15);
    check("ch2 idle high", hi[2], 0);

    // Ramp up 0->4, then down 4->1, on ch2.
    do_write(2, 4, 1);
    for (int p = 0; p < 5; p++) begin
      measure();
      check($sformatf("ch2 up period%0d", p), hi[2], FADE ? ((p < 4) ? p + 1 : 4) : 4);
      if (p == 0) check("busy mid fade", int'(fade_busy), FADE);
    end
    check("busy after ramp", int'(fade_busy), 0);
    do_write(2, 1, 1);
    for (int p = 0; p < 3; p++) begin
      measure();
      check($sformatf("ch2 down period%0d", p), hi[2], FADE ? 3 - p : 1);
    end
    settle();

    // Write issued on the boundary clock (cnt==14).
    wait_ps();
    step(14);
    do_write(1, 8, 1);
    check("write hit boundary", int'(period_start), 1);
    measure();
    check("ch1 keeps old duty", hi[1], 0);
    measure();
    check("ch1 new duty next period", hi[1], FADE ? 1 : 8);
    settle();

    // Channel index out of range, then ch_on gating.
    do_write(7, 9, 0);
    step(1);
    check("wr_err one pulse", int'(wr_bus.wr_err), 0);
    do_write(6, 3, 0);
    step(2);
    check("bad write no change", int'(fade_busy), 0);
    do_write(3, 15, 1);
    settle();
    check("ch3 on at duty15", int'(led_out[3]), 1);
    ch_on[3] = 1'b0;
    step(1);
    check("ch3 gated off", int'(led_out[3]), 0);
    check("ch5 unaffected", int'(led_out[5]), 1);
    ch_on[3] = 1'b1;

    // PRESCALE=3 instance.
    n = 0;
    while (!period_start3 && n < 200) begin
      step(1);
      n++;
    end
    n = 0;
    do begin
      step(1);
      n++;
    end while (!period_start3 && n < 200);
    check("ps3 period clocks", n, 45);
    step(1);
    check("ps3 pulse width", int'(period_start3), 0);
    wr_bus3.wr_en   = 1'b1;
    wr_bus3.wr_ch   = 3'd0;
    wr_bus3.wr_duty = 4'd5;
    step(1);
    wr_bus3.wr_en = 1'b0;
    check("ps3 wr_ack", int'(wr_bus3.wr_ack), 1);
    step(6 * 45 + 10);
    check("ps3 settled", int'(fade_busy3), 0);
    n = 0;
    while (!period_start3 && n < 200) begin
      step(1);
      n++;
    end
    n = 0;
    for (int t = 0; t < 45; t++) begin
      step(1);
      n += int'(led_out3[0]);
    end
    check("ps3 duty5 high clocks", n, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
